rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
Control FSM for the multicycle RV32 core. Decodes the latched instruction and sequences fetch, decode, execute, memory and writeback. It produces the 3-bit ALU operation code and all datapath mux selects and write enables. It consumes the ALU's branch_zero flag for conditional branches.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); not to be overridden except in test.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
instr  input  32  instruction register contents (valid from DECODE onward)
mem_ready  input  1  memory handshake: access complete this cycle
branch_zero  input  1  ALU result == 0 flag
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  memory write (store) qualifier of mem_req
ir_we  output  1  load instruction register
pc_we  output  1  load PC
old_pc_we  output  1  save PC of current instruction
alu_out_we  output  1  load ALU output register
reg_we  output  1  register file write
alu_prog  output  3  ALU op code from shared op list (ALU_ADD/OR/SRL/SLTU/SUB)
src_a_sel  output  2  0=PC, 1=old PC, 2=rs1, 3=zero
src_b_sel  output  2  0=rs2, 1=imm, 2=constant 4
pc_src  output  1  0=ALU result, 1=ALU output register
wb_sel  output  1  0=ALU output register, 1=memory read data
illegal  output  1  sticky unsupported-instruction flag
state  output  4  current FSM state, for debug

Behaviour:
- clk is the single clock. rst is asynchronous and active-high. Reset forces state=FETCH and illegal=0, effective immediately, including mid-access. All outputs are decoded combinationally from state/instr/inputs. With rst asserted, every strobe is 0, alu_prog=ALU_ADD and every select is 0.
- Default for all outputs in all states: strobes 0, selects 0, alu_prog=ALU_ADD.
- States (encodings): FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, EXEC_LUI=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JAL=11, ILLEGAL=15.
- FETCH: mem_req=1, mem_we=0. Stays in FETCH while mem_ready=0. When mem_ready=1, the following are asserted the same cycle: ir_we=1, old_pc_we=1, pc_we=1, src_a=PC, src_b=4, ALU_ADD, pc_src=0. Next state is DECODE.
- DECODE: src_a=old PC, src_b=imm, ALU_ADD, alu_out_we=1 (branch target precompute). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> EXEC_LUI
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL (only with the optional feature)
  - anything else -> ILLEGAL
- EXEC_R: src_a=rs1, src_b=rs2, alu_out_we=1. funct3/funct7 map as follows:
  - 000/0000000 -> ADD
  - 000/0100000 -> SUB
  - 110/0000000 -> OR
  - 101/0000000 -> SRL
  - 011/0000000 -> SLTU
  - any other combination -> ILLEGAL, with no alu_out_we
  - Valid combinations go to WB_ALU.
- EXEC_I: src_a=rs1, src_b=imm, alu_out_we=1. funct3 maps 000->ADD, 110->OR, 011->SLTU. funct3=101 with funct7=0000000 maps to SRL. Anything else goes to ILLEGAL. Valid combinations go to WB_ALU.
- EXEC_LUI: src_a=zero, src_b=imm, ALU_ADD, alu_out_we=1. Next state is WB_ALU.
- MEM_ADDR: src_a=rs1, src_b=imm, ALU_ADD, alu_out_we=1. Only funct3=010 (word) is legal, otherwise ILLEGAL. Load goes to MEM_RD; store goes to MEM_WR.
- MEM_RD: mem_req=1, held while mem_ready=0. On mem_ready, next state is WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, held while mem_ready=0. On mem_ready, next state is FETCH.
- WB_ALU: reg_we=1, wb_sel=0. Next state is FETCH.
- WB_MEM: reg_we=1, wb_sel=1. Next state is FETCH.
- BRANCH: src_a=rs1, src_b=rs2, ALU_SUB, pc_src=1. funct3=000 (BEQ): pc_we=branch_zero. funct3=001 (BNE): pc_we=!branch_zero. Other funct3 -> ILLEGAL, pc_we=0. Legal branches go to FETCH.
- ILLEGAL: illegal=1 and all strobes 0. The FSM stays here until rst (terminal state).
- Latencies (mem_ready immediate):
  - R/I/LUI: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles

Optional Feature:
RV_CTRL_JAL_EN. When defined, opcode 1101111 goes to JAL. In JAL the following are asserted in the same cycle:
- src_a=old PC, src_b=4, ALU_ADD, reg_we=1, wb_sel=0 (link write uses the value via the alu_out path: the datapath's alu_out is loaded in DECODE with the target, so JAL writes PC+4 directly and the datapath routes the ALU result when wb_sel=0 in JAL)
- pc_src=1, pc_we=1 (target from the DECODE precompute)
Next state is FETCH. When not defined, opcode 1101111 goes to ILLEGAL and the JAL state is not built.

Test Plan:
- Reset mid-MEM_RD (mem_ready=0, rst pulse) -> state=0 immediately, mem_req=0; next fetch proceeds normally.
- FETCH with mem_ready low 3 cycles, then high -> mem_req held 4 cycles; ir_we/pc_we/old_pc_we a single pulse on cycle 4; state=1 next.
- instr=0x40B50533 (sub x10,x10,x11) -> DECODE, EXEC_R with alu_prog=ALU_SUB, src_a=2, src_b=0; WB_ALU reg_we=1 wb_sel=0; back to FETCH.
- instr=0x00B50463 (beq) with branch_zero=1 -> BRANCH pc_we=1 pc_src=1 alu_prog=ALU_SUB. Repeat with branch_zero=0 -> pc_we=0. BNE variant gives inverted results.
- instr=0x0000A503 (lw) -> MEM_ADDR ALU_ADD src_b=1; MEM_RD waits for mem_ready with mem_we=0; WB_MEM reg_we=1 wb_sel=1.
- instr=0x02B50533 (funct7=0000001) -> ILLEGAL, illegal=1 persists 10 cycles; clears only on rst. With RV_CTRL_JAL_EN undefined, 0x0080006F also -> illegal=1.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: control FSM for the multicycle RV32 core.
// Sequences fetch/decode/execute/memory/writeback and decodes every datapath
// strobe, mux select and ALU op combinationally from the current state, the
// latched instruction and the memory/ALU handshake inputs.
// Optional feature: define RV_CTRL_JAL_EN to build the JAL state; otherwise
// opcode 1101111 is treated as an unsupported instruction.
module rv_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        old_pc_we,
    output logic        alu_out_we,
    output logic        reg_we,
    output logic [2:0]  alu_prog,
    output logic [1:0]  src_a_sel,
    output logic [1:0]  src_b_sel,
    output logic        pc_src,
    output logic        wb_sel,
    output logic        illegal,
    output logic [3:0]  state
);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_SRL  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;
    localparam logic [1:0] SRC_B_RS2   = 2'd0;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;
    localparam logic [1:0] SRC_B_FOUR  = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_EXEC_LUI = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_ILLEGAL  = 4'd15
    } state_t;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices and immediates are consumed by the datapath, not here.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // State register; reset is asynchronous so it also aborts a pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= state_t'(RESET_STATE);
        else     state_q <= state_d;
    end

    // Next-state and output decode; all outputs forced idle while rst is high.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        old_pc_we  = 1'b0;
        alu_out_we = 1'b0;
        reg_we     = 1'b0;
        alu_prog   = ALU_ADD;
        src_a_sel  = SRC_A_PC;
        src_b_sel  = SRC_B_RS2;
        pc_src     = 1'b0;
        wb_sel     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    old_pc_we = 1'b1;
                    pc_we     = 1'b1;
                    src_a_sel = SRC_A_PC;
                    src_b_sel = SRC_B_FOUR;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target precompute into the ALU output register.
                src_a_sel  = SRC_A_OLDPC;
                src_b_sel  = SRC_B_IMM;
                alu_out_we = 1'b1;
                case (opcode)
                    7'b0110011: state_d = S_EXEC_R;
                    7'b0010011: state_d = S_EXEC_I;
                    7'b0110111: state_d = S_EXEC_LUI;
                    7'b0000011,
                    7'b0100011: state_d = S_MEM_ADDR;
                    7'b1100011: state_d = S_BRANCH;
`ifdef RV_CTRL_JAL_EN
                    7'b1101111: state_d = S_JAL;
`endif
                    default:    state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_RS2;
                state_d   = S_WB_ALU;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: alu_prog = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_prog = ALU_SUB;
                    {7'b0000000, 3'b110}: alu_prog = ALU_OR;
                    {7'b0000000, 3'b101}: alu_prog = ALU_SRL;
                    {7'b0000000, 3'b011}: alu_prog = ALU_SLTU;
                    default:              state_d  = S_ILLEGAL;
                endcase
                alu_out_we = (state_d == S_WB_ALU);
            end
            S_EXEC_I: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_IMM;
                state_d   = S_WB_ALU;
                case (funct3)
                    3'b000: alu_prog = ALU_ADD;
                    3'b110: alu_prog = ALU_OR;
                    3'b011: alu_prog = ALU_SLTU;
                    3'b101: begin
                        if (funct7 == 7'b0000000) alu_prog = ALU_SRL;
                        else                      state_d  = S_ILLEGAL;
                    end
                    default: state_d = S_ILLEGAL;
                endcase
                alu_out_we = (state_d == S_WB_ALU);
            end
            S_EXEC_LUI: begin
                src_a_sel  = SRC_A_ZERO;
                src_b_sel  = SRC_B_IMM;
                alu_out_we = 1'b1;
                state_d    = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_IMM;
                if (funct3 == 3'b010) begin
                    alu_out_we = 1'b1;
                    // opcode bit 5 separates store (0100011) from load (0000011).
                    state_d    = opcode[5] ? S_MEM_WR : S_MEM_RD;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_WB_ALU: begin
                reg_we  = 1'b1;
                wb_sel  = 1'b0;
                state_d = S_FETCH;
            end
            S_WB_MEM: begin
                reg_we  = 1'b1;
                wb_sel  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_RS2;
                alu_prog  = ALU_SUB;
                pc_src    = 1'b1;
                state_d   = S_FETCH;
                case (funct3)
                    3'b000:  pc_we   = branch_zero;
                    3'b001:  pc_we   = !branch_zero;
                    default: state_d = S_ILLEGAL;
                endcase
            end
`ifdef RV_CTRL_JAL_EN
            S_JAL: begin
                // Link value PC+4 goes straight from the ALU; target comes
                // from the ALU output register loaded in DECODE.
                src_a_sel = SRC_A_OLDPC;
                src_b_sel = SRC_B_FOUR;
                reg_we    = 1'b1;
                wb_sel    = 1'b0;
                pc_src    = 1'b1;
                pc_we     = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_ILLEGAL;
        endcase

        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            old_pc_we  = 1'b0;
            alu_out_we = 1'b0;
            reg_we     = 1'b0;
            alu_prog   = ALU_ADD;
            src_a_sel  = SRC_A_PC;
            src_b_sel  = SRC_B_RS2;
            pc_src     = 1'b0;
            wb_sel     = 1'b0;
        end
    end

    assign illegal = (state_q == S_ILLEGAL) && !rst;
    assign state   = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed testbench for rv_multicycle_ctrl.
// Strobes are viewed as {mem_req,mem_we,ir_we,pc_we,old_pc_we,alu_out_we,reg_we}
// and selects as {alu_prog,src_a_sel,src_b_sel,pc_src,wb_sel}.
module tb_rv_multicycle_ctrl;

    localparam logic [2:0] ADD = 3'd0, OR_ = 3'd1, SRL = 3'd2, SLTU = 3'd3, SUB = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_zero = 1'b0;
    logic        mem_req, mem_we, ir_we, pc_we, old_pc_we, alu_out_we, reg_we;
    logic [2:0]  alu_prog;
    logic [1:0]  src_a_sel, src_b_sel;
    logic        pc_src, wb_sel, illegal;
    logic [3:0]  state;

    logic [6:0]  strobes;
    logic [8:0]  sels;
    assign strobes = {mem_req, mem_we, ir_we, pc_we, old_pc_we, alu_out_we, reg_we};
    assign sels    = {alu_prog, src_a_sel, src_b_sel, pc_src, wb_sel};

    int checks = 0;
    int errors = 0;

    rv_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .branch_zero(branch_zero), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .old_pc_we(old_pc_we),
        .alu_out_we(alu_out_we), .reg_we(reg_we), .alu_prog(alu_prog),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .pc_src(pc_src),
        .wb_sel(wb_sel), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        branch_zero = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Complete a fetch of ins with an immediate mem_ready; ends in DECODE.
    task automatic fetch(input logic [31:0] ins);
        mem_ready = 1'b1;
        instr = ins;
        tick();
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({state, illegal, strobes, sels} !== {4'd0, 1'b0, 7'b0, 9'b0}) begin
            errors++;
            $display("FAIL reset_idle: got st=%0d ill=%b stb=%b sel=%b want 0/0/0/0", state, illegal, strobes, sels);
        end
        do_reset();
        checks++;
        if ({state, strobes} !== {4'd0, 7'b1000000}) begin
            errors++;
            $display("FAIL reset_release: got st=%0d stb=%b want 0 1000000", state, strobes);
        end
    endtask

    task automatic test_fetch_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({state, strobes, sels} !== {4'd0, 7'b1000000, 9'b0}) begin
                errors++;
                $display("FAIL fetch_wait%0d: got st=%0d stb=%b sel=%b want 0 1000000 0", i, state, strobes, sels);
            end
            tick();
        end
        mem_ready = 1'b1;
        instr = 32'h40B50533;
        #1;
        checks++;
        if ({state, strobes, sels} !== {4'd0, 7'b1011100, 9'b000_00_10_0_0}) begin
            errors++;
            $display("FAIL fetch_done: got st=%0d stb=%b sel=%b want 0 1011100 000001000", state, strobes, sels);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, strobes, sels} !== {4'd1, 7'b0000010, 9'b000_01_01_0_0}) begin
            errors++;
            $display("FAIL decode: got st=%0d stb=%b sel=%b want 1 0000010 000010100", state, strobes, sels);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins [9]  = '{32'h00B50533, 32'h40B50533, 32'h00B56533, 32'h00B55533,
                                  32'h00B53533, 32'h00150513, 32'h00156513, 32'h00153513,
                                  32'h00155513};
        logic [3:0]  est [9]  = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
        logic [2:0]  eop [9]  = '{ADD, SUB, OR_, SRL, SLTU, ADD, OR_, SLTU, SRL};
        logic [1:0]  esb;
        for (int i = 0; i < 9; i++) begin
            do_reset();
            fetch(ins[i]);
            tick();
            esb = (est[i] == 4'd2) ? 2'd0 : 2'd1;
            checks++;
            if ({state, strobes, sels} !== {est[i], 7'b0000010, eop[i], 2'd2, esb, 2'b00}) begin
                errors++;
                $display("FAIL exec%0d: got st=%0d stb=%b sel=%b want %0d 0000010 op=%0d b=%0d",
                         i, state, strobes, sels, est[i], eop[i], esb);
            end
            tick();
            checks++;
            if ({state, strobes, sels} !== {4'd8, 7'b0000001, 9'b0}) begin
                errors++;
                $display("FAIL wb_alu%0d: got st=%0d stb=%b sel=%b want 8 0000001 0", i, state, strobes, sels);
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                errors++;
                $display("FAIL wb_ret%0d: got st=%0d want 0", i, state);
            end
        end
    endtask

    task automatic test_lui();
        do_reset();
        fetch(32'h123452B7);
        tick();
        checks++;
        if ({state, strobes, sels} !== {4'd4, 7'b0000010, 9'b000_11_01_0_0}) begin
            errors++;
            $display("FAIL lui: got st=%0d stb=%b sel=%b want 4 0000010 000110100", state, strobes, sels);
        end
        tick();
        checks++;
        if ({state, reg_we} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL lui_wb: got st=%0d we=%b want 8 1", state, reg_we);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [2] = '{32'h00B50463, 32'h00B51463};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            fetch(ins[i]);
            tick();
            branch_zero = 1'b1;
            #1;
            checks++;
            if ({state, strobes, sels} !== {4'd10, (i == 0) ? 7'b0001000 : 7'b0000000, 9'b100_10_00_1_0}) begin
                errors++;
                $display("FAIL branch%0d_bz1: got st=%0d stb=%b sel=%b want 10 pc_we=%0d sel=100100010", i, state, strobes, sels, (i == 0));
            end
            branch_zero = 1'b0;
            #1;
            checks++;
            if (pc_we !== (i != 0)) begin
                errors++;
                $display("FAIL branch%0d_bz0: got pc_we=%b want %0d", i, pc_we, (i != 0));
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                errors++;
                $display("FAIL branch%0d_ret: got st=%0d want 0", i, state);
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        fetch(32'h0000A503);
        tick();
        checks++;
        if ({state, strobes, sels} !== {4'd5, 7'b0000010, 9'b000_10_01_0_0}) begin
            errors++;
            $display("FAIL lw_addr: got st=%0d stb=%b sel=%b want 5 0000010 000100100", state, strobes, sels);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({state, strobes} !== {4'd6, 7'b1000000}) begin
                errors++;
                $display("FAIL lw_wait%0d: got st=%0d stb=%b want 6 1000000", i, state, strobes);
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({state, strobes, sels} !== {4'd9, 7'b0000001, 9'b000_00_00_0_1}) begin
            errors++;
            $display("FAIL lw_wb: got st=%0d stb=%b sel=%b want 9 0000001 000000001", state, strobes, sels);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL lw_ret: got st=%0d want 0", state);
        end
    endtask

    task automatic test_store();
        do_reset();
        fetch(32'h00B52023);
        tick();
        tick();
        checks++;
        if ({state, strobes} !== {4'd7, 7'b1100000}) begin
            errors++;
            $display("FAIL sw_mem: got st=%0d stb=%b want 7 1100000", state, strobes);
        end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL sw_ret: got st=%0d want 0", state);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        fetch(32'h0000A503);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, strobes, sels} !== {4'd0, 7'b0, 9'b0}) begin
            errors++;
            $display("FAIL rst_mid: got st=%0d stb=%b sel=%b want 0 0 0", state, strobes, sels);
        end
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, strobes} !== {4'd0, 7'b1011100}) begin
            errors++;
            $display("FAIL rst_refetch: got st=%0d stb=%b want 0 1011100", state, strobes);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL rst_decode: got st=%0d want 1", state);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        fetch(32'h02B50533);
        tick();
        checks++;
        if (alu_out_we !== 1'b0) begin
            errors++;
            $display("FAIL ill_exec_we: got %b want 0", alu_out_we);
        end
        tick();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({state, illegal, strobes} !== {4'd15, 1'b1, 7'b0}) begin
                errors++;
                $display("FAIL ill_hold%0d: got st=%0d ill=%b stb=%b want 15 1 0", i, state, illegal, strobes);
            end
            tick();
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, illegal} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL ill_clear: got st=%0d ill=%b want 0 0", state, illegal);
        end
        do_reset();
        fetch(32'h0080006F);
        tick();
`ifdef RV_CTRL_JAL_EN
        checks++;
        if ({state, strobes, sels} !== {4'd11, 7'b0001001, 9'b000_01_10_1_0}) begin
            errors++;
            $display("FAIL jal: got st=%0d stb=%b sel=%b want 11 0001001 000011010", state, strobes, sels);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL jal_ret: got st=%0d want 0", state);
        end
`else
        checks++;
        if ({state, illegal} !== {4'd15, 1'b1}) begin
            errors++;
            $display("FAIL jal_illegal: got st=%0d ill=%b want 15 1", state, illegal);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_alu_ops();
        test_lui();
        test_branch();
        test_load();
        test_store();
        test_reset_mid_access();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
